decryption_r1: RTL and testbench
================================

# decryption_r1

Responder-side counterpart of the round-1 encryption stage in the Diffie-Hellman key-exchange datapath. It derives the shared key k = exp mod p with an iterative 64-cycle restoring reduction and sends the challenge c1 = k ^ r2 to the peer. It then accepts the peer's reply c2, recovers r1 = k ^ c2 and flags whether r1 matches the expected nonce. The block sits between the modular-exponentiation result and the round-2 handshake logic.

## Interface
- DW, 64, width of exp, nonces and ciphertexts
- PW, 32, width of modulus p
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- exp  in  DW  exponentiation result; latched on accepted start
- p  in  PW  modulus; latched on accepted start
- r2  in  DW  own nonce; latched on accepted start
- r1_ref  in  DW  expected peer nonce; sampled with c2_valid
- c2  in  DW  peer ciphertext
- c2_valid  in  1  c2 qualifier; sampled only in WAIT_C2
- busy  out  1  high in every state except IDLE
- c1  out  DW  challenge k ^ r2
- c1_valid  out  1  one-cycle strobe qualifying c1
- r1  out  DW  recovered nonce k ^ c2
- true_o  out  1  r1 == r1_ref
- err  out  1  p was zero
- done  out  1  one-cycle completion strobe

## Operation
- FSM states: IDLE, REDUCE, SEND, WAIT_C2, FIN.
- IDLE: on start=1, latch exp, p and r2. Clear rem and the 6-bit bit counter. Go to REDUCE, or to FIN with err=1 if p==0.
- REDUCE: process one exp bit per cycle, MSB first. The step is t = {rem, exp[63-cnt]} (33 bits); rem = (t >= p) ? t - p : t. Leave after the 64th bit (cnt==63).
- k = {32'b0, rem[31:0]}, always < p.
- SEND: c1 <= k ^ r2 and c1_valid=1 for this state only. Go to WAIT_C2.
- WAIT_C2: hold until c2_valid=1. Then r1 <= k ^ c2, true_o <= (k ^ c2) == r1_ref. Go to FIN. No timeout.
- FIN: done=1 for one cycle, then IDLE.
- Outputs c1, r1, true_o and err hold their values until the next accepted start, which clears true_o and err.
- start outside IDLE is ignored. c2_valid outside WAIT_C2 is ignored and not buffered.
- err path: c1=0, c1_valid never asserts, r1=0, true_o=0, done=1.

## Timing
- Reset values: c1=0, c1_valid=0, r1=0, true_o=0, err=0, done=0, busy=0. FSM goes to IDLE, counter 0.
- Start sampled at edge E0:
  - busy high from E0+1.
  - REDUCE occupies cycles E0+1 through E0+64.
  - c1/c1_valid are registered at E0+65 and high for that one cycle.
  - WAIT_C2 is entered from E0+66.
- A c2_valid sampled at edge Ec produces r1, true_o and done=1 from Ec+1; busy falls at Ec+2.
- p==0: done high at E0+1 to E0+2 with err=1.
- rst=1 in any state aborts at the next edge. All outputs return to reset values and latched operands are discarded.
- rst and start in the same cycle: rst wins.
- Back-to-back operation: start is accepted in the first IDLE cycle after FIN.
- No combinational path from inputs to outputs.

## Structure
- Package dh_pkg: DW, PW, the state enum, and REDUCE_CYCLES=64.
- Sub-module mod_reduce holds the bit-serial remainder engine. It has load/step/done ports, a 33-bit rem register and its own counter, and is reused by the encryption side.
- Top level holds the FSM, the operand registers and the XOR/compare logic.

## Test plan
- exp=100, p=23, r2=0x5 -> c1=0xD at E0+65. Then c2=0x123C, r1_ref=0x1234 -> r1=0x1234, true_o=1, done one cycle.
- Same flow with r1_ref=0x1235 -> r1=0x1234, true_o=0, err=0.
- exp=64'hFFFF_FFFF_FFFF_FFFF, p=32'hFFFF_FFFF, r2=0xA5 -> k=0, c1=0xA5. Also exp=7, p=23 -> k=7.
- p=0 -> err=1, done at E0+1, c1_valid never asserts, true_o=0.
- rst pulsed at E0+30 -> all outputs 0, busy=0. A new start with exp=100, p=23 still gives c1=0xD at 65 cycles.
- start during REDUCE and c2_valid during REDUCE/SEND -> both ignored. c1 timing unchanged, and the flow stays in WAIT_C2 until a later c2_valid.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman key-exchange datapath.
// Holds the operand widths, the reduction length and the FSM state
// encoding used by the round-1 encryption/decryption stages.
package dh_pkg;

  localparam int DW            = 64;  // exp, nonce and ciphertext width
  localparam int PW            = 32;  // modulus width
  localparam int REDUCE_CYCLES = 64;  // one exp bit per cycle
  localparam int CNT_W         = 6;   // bit counter width, 2**CNT_W == DW

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REDUCE  = 3'd1;
  localparam state_t ST_SEND    = 3'd2;
  localparam state_t ST_WAIT_C2 = 3'd3;
  localparam state_t ST_FIN     = 3'd4;

endpackage

// File: rtl/decryption_r1_if.sv
// Handshake/data bundle of the round-1 decryption stage.
// slave  : the decryption_r1 block (operands/c2 in, c1/r1/status out)
// master : the surrounding handshake logic (or a testbench)
interface decryption_r1_if;
  import dh_pkg::*;

  logic          start;
  logic [DW-1:0] exp;
  logic [PW-1:0] p;
  logic [DW-1:0] r2;
  logic [DW-1:0] r1_ref;
  logic [DW-1:0] c2;
  logic          c2_valid;
  logic          busy;
  logic [DW-1:0] c1;
  logic          c1_valid;
  logic [DW-1:0] r1;
  logic          true_o;
  logic          err;
  logic          done;

  modport slave (
    input  start, exp, p, r2, r1_ref, c2, c2_valid,
    output busy, c1, c1_valid, r1, true_o, err, done
  );

  modport master (
    output start, exp, p, r2, r1_ref, c2, c2_valid,
    input  busy, c1, c1_valid, r1, true_o, err, done
  );

endinterface

// File: rtl/mod_reduce.sv
// Bit-serial restoring reduction: rem = x mod m, one bit of x per step,
// MSB first. Shared between the encryption and decryption stages.
// Ports:
//   clk, rst  clock / synchronous active-high reset (counter only)
//   load      clear remainder and bit counter
//   step      consume the next bit of x
//   x, m      dividend and modulus, held stable by the caller while stepping
//   rem       current remainder (always < m, so rem[PW] stays 0)
//   rem_nxt   remainder after the current step
//   done      high during the step that consumes the last bit of x
module mod_reduce
  import dh_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] x,
  input  logic [PW-1:0] m,
  output logic [PW:0]   rem,
  output logic [PW:0]   rem_nxt,
  output logic          done
);

  logic [CNT_W-1:0] cnt;
  logic [PW:0]      t;

  // ~cnt selects x[DW-1-cnt] because DW is exactly 2**CNT_W.
  always_comb begin
    t       = {rem[PW-1:0], x[~cnt]};
    rem_nxt = (t >= {1'b0, m}) ? t - {1'b0, m} : t;
    done    = step && (cnt == CNT_W'(REDUCE_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load)      rem <= '0;
    else if (step) rem <= rem_nxt;
  end

endmodule

// File: rtl/decryption_r1.sv
// Responder-side round-1 stage: derives k = exp mod p, sends c1 = k ^ r2,
// then recovers r1 = k ^ c2 from the peer reply and flags r1 == r1_ref.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset, aborts any operation
//   bus  decryption_r1_if.slave: start/exp/p/r2 request, c2/c2_valid/r1_ref
//        reply, busy/c1/c1_valid/r1/true_o/err/done results
module decryption_r1
  import dh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  decryption_r1_if.slave   bus
);

  state_t        state;
  logic [DW-1:0] exp_q;
  logic [PW-1:0] p_q;
  logic [DW-1:0] r2_q;
  logic [DW-1:0] c1_q;
  logic [DW-1:0] r1_q;
  logic          true_q;
  logic          err_q;

  logic          accept;
  logic          red_step;
  logic          red_done;
  logic [PW:0]   red_rem;
  logic [PW:0]   red_rem_nxt;
  logic [DW-1:0] k;
  logic [DW-1:0] k_nxt;
  logic [DW-1:0] r1_calc;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign red_step = (state == ST_REDUCE);

  mod_reduce u_reduce (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (red_step),
    .x       (exp_q),
    .m       (p_q),
    .rem     (red_rem),
    .rem_nxt (red_rem_nxt),
    .done    (red_done)
  );

  // Remainder is below p, so zero-extending the 33-bit value gives k.
  assign k       = {{(DW-PW-1){1'b0}}, red_rem};
  assign k_nxt   = {{(DW-PW-1){1'b0}}, red_rem_nxt};
  assign r1_calc = k ^ bus.c2;

  // Operands are only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      exp_q <= bus.exp;
      p_q   <= bus.p;
      r2_q  <= bus.r2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      c1_q   <= '0;
      r1_q   <= '0;
      true_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            c1_q   <= '0;
            r1_q   <= '0;
            true_q <= 1'b0;
            err_q  <= (bus.p == '0);
            state  <= (bus.p == '0) ? ST_FIN : ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          // c1 is captured from the final step so it is valid in SEND.
          if (red_done) begin
            c1_q  <= k_nxt ^ r2_q;
            state <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT_C2;
        ST_WAIT_C2: begin
          if (bus.c2_valid) begin
            r1_q   <= r1_calc;
            true_q <= (r1_calc == bus.r1_ref);
            state  <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.c1_valid = (state == ST_SEND);
  assign bus.done     = (state == ST_FIN);
  assign bus.c1       = c1_q;
  assign bus.r1       = r1_q;
  assign bus.true_o   = true_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_decryption_r1.sv
// Scoreboard bench for decryption_r1: expected c1/r1/true_o/err pushed when a
// request is driven, popped and compared when done is observed.
module tb_decryption_r1;
  import dh_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decryption_r1_if bus ();

  decryption_r1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] c1;
    logic [63:0] r1;
    logic        tr;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_c1"},       bus.c1, 64'd0);
    chk({tag, "_c1_valid"}, bus.c1_valid, 64'd0);
    chk({tag, "_r1"},       bus.r1, 64'd0);
    chk({tag, "_true_o"},   bus.true_o, 64'd0);
    chk({tag, "_err"},      bus.err, 64'd0);
    chk({tag, "_done"},     bus.done, 64'd0);
    chk({tag, "_busy"},     bus.busy, 64'd0);
  endtask

  // One full transaction; noise=1 injects a start during REDUCE and c2_valid
  // pulses during REDUCE and SEND, all of which must be ignored.
  task automatic run(input logic [63:0] e, input logic [31:0] m, input logic [63:0] r2v,
                     input logic [63:0] c2v, input logic [63:0] refv, input bit noise);
    exp_t        x;
    exp_t        got;
    logic [63:0] k;
    int          lat;
    k    = (m == 32'd0) ? 64'd0 : e % {32'd0, m};
    x.c1 = (m == 32'd0) ? 64'd0 : (k ^ r2v);
    x.r1 = (m == 32'd0) ? 64'd0 : (k ^ c2v);
    x.tr = (m != 32'd0) && ((k ^ c2v) == refv);
    x.er = (m == 32'd0);
    sb.push_back(x);

    bus.exp = e; bus.p = m; bus.r2 = r2v; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.exp = '1; bus.p = 32'd5; bus.r2 = '0;
    chk("busy_after_start", bus.busy, 64'd1);

    if (m != 32'd0) begin
      lat = 0;
      while (bus.c1_valid !== 1'b1 && lat < 200) begin
        if (noise && lat == 10) begin bus.start = 1'b1; bus.exp = 64'd1; bus.p = 32'd3; end
        if (noise && lat == 11) bus.start = 1'b0;
        if (noise && lat == 20) begin bus.c2 = 64'hDEAD; bus.r1_ref = 64'hDEAD; bus.c2_valid = 1'b1; end
        if (noise && lat == 21) bus.c2_valid = 1'b0;
        tick;
        lat++;
      end
      chk("c1_latency", lat, 64'd64);
      chk("c1_at_valid", bus.c1, x.c1);
      if (noise) begin
        bus.c2 = 64'hBEEF; bus.r1_ref = 64'hBEEF; bus.c2_valid = 1'b1;
      end
      tick;
      bus.c2_valid = 1'b0;
      chk("c1_valid_pulse", bus.c1_valid, 64'd0);
      chk("done_early", bus.done, 64'd0);
      if (noise) begin
        tick; tick;
        chk("wait_c2_hold_busy", bus.busy, 64'd1);
        chk("wait_c2_hold_done", bus.done, 64'd0);
      end
      bus.c2 = c2v; bus.r1_ref = refv; bus.c2_valid = 1'b1;
      tick;
      bus.c2_valid = 1'b0;
    end

    lat = 0;
    while (bus.done !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    chk("done_latency", lat, 64'd0);
    got = sb.pop_front();
    chk("c1_held", bus.c1, got.c1);
    chk("r1", bus.r1, got.r1);
    chk("true_o", bus.true_o, {63'd0, got.tr});
    chk("err", bus.err, {63'd0, got.er});
    chk("c1_valid_at_done", bus.c1_valid, 64'd0);
    tick;
    chk("done_pulse", bus.done, 64'd0);
    chk("busy_idle", bus.busy, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e, r2v, c2v, refv;
    logic [31:0] m;
    rst = 1'b1;
    bus.start = 1'b0; bus.exp = '0; bus.p = '0; bus.r2 = '0;
    bus.r1_ref = '0; bus.c2 = '0; bus.c2_valid = 1'b0;
    tick; tick;
    chk_cleared("reset");
    rst = 1'b0;
    tick;

    run(64'd100, 32'd23, 64'h5, 64'h123C, 64'h1234, 1'b0);
    run(64'd100, 32'd23, 64'h5, 64'h123C, 64'h1235, 1'b0);
    run(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'hA5, 64'h77, 64'h77, 1'b0);
    run(64'd7, 32'd23, 64'h0, 64'h10, 64'h17, 1'b0);
    run(64'd12345, 32'd0, 64'h99, 64'h1, 64'h1, 1'b0);
    // back-to-back: start in the first IDLE cycle after FIN
    run(64'd100, 32'd23, 64'h5, 64'h123C, 64'h1234, 1'b0);

    // abort mid-reduction
    bus.exp = 64'd100; bus.p = 32'd23; bus.r2 = 64'h5; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (29) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_cleared("abort");

    // reset wins over start
    rst = 1'b1; bus.start = 1'b1; bus.p = 32'd23;
    tick;
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_over_start_busy", bus.busy, 64'd0);
    tick;
    chk("rst_over_start_idle", bus.busy, 64'd0);

    run(64'd100, 32'd23, 64'h5, 64'h123C, 64'h1234, 1'b0);
    run(64'd100, 32'd23, 64'h5, 64'h123C, 64'h1234, 1'b1);

    for (int i = 0; i < 4; i++) begin
      e    = {$urandom, $urandom};
      m    = $urandom | 32'h8000_0001;
      r2v  = {$urandom, $urandom};
      c2v  = {$urandom, $urandom};
      refv = (i % 2 == 0) ? (c2v ^ (e % {32'd0, m})) : {$urandom, $urandom};
      run(e, m, r2v, c2v, refv, 1'b0);
    end

    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
